multisim_chan_arb: RTL

MULTISIM_CHAN_ARB -- requirements
Module: multisim_chan_arb

---
 rtl/multisim_chan_arb.sv | 116 +++++++++++
 1 files changed

// File: rtl/multisim_chan_arb.sv
// multisim_chan_arb: round-robin merge of per-channel ingress FIFOs onto one tagged link,
// plus demux of a tagged return link into per-channel show-ahead egress FIFOs.
module multisim_chan_arb #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4,
  localparam int IDX_W = $clog2(NUM_CHANNELS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CHANNELS-1:0]            in_vld,
  output logic [NUM_CHANNELS-1:0]            in_rdy,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic                               out_vld,
  input  logic                               out_rdy,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [IDX_W-1:0]                   out_chan,
  input  logic                               ret_vld,
  output logic                               ret_rdy,
  input  logic [DATA_WIDTH-1:0]              ret_data,
  input  logic [IDX_W-1:0]                   ret_chan,
  output logic [NUM_CHANNELS-1:0]            chan_vld,
  input  logic [NUM_CHANNELS-1:0]            chan_rdy,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] chan_data,
  output logic                               bad_chan_err,
  output logic                               idle
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic rdy_en;
  logic load;
  logic gnt_vld;
  logic ret_ok;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] gnt;
  logic [IDX_W-1:0] cand;
  logic [NUM_CHANNELS-1:0] ig_full, ig_empty, ig_push, ig_pop;
  logic [NUM_CHANNELS-1:0] eg_full, eg_empty, eg_push, eg_pop, ret_sel;
  logic [DATA_WIDTH-1:0] ig_head [NUM_CHANNELS];

  // in_rdy stays low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdy_en <= 1'b0;
    else rdy_en <= 1'b1;

  assign in_rdy = rdy_en ? ~ig_full : '0;
  assign ig_push = in_vld & in_rdy;
  assign load = !out_vld || out_rdy;
  assign ig_pop = (load && gnt_vld) ? NUM_CHANNELS'(1) << gnt : '0;

  // descending scan so the smallest offset from last_grant wins
  always_comb begin
    gnt_vld = 1'b0;
    gnt = '0;
    cand = '0;
    for (int k = NUM_CHANNELS; k >= 1; k--) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_CHANNELS);
      gnt_vld = !ig_empty[cand] ? 1'b1 : gnt_vld;
      gnt = !ig_empty[cand] ? cand : gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_data <= '0;
      out_chan <= '0;
      last_grant <= IDX_W'(NUM_CHANNELS - 1);
    end else if (load) begin
      out_vld <= gnt_vld;
      if (gnt_vld) begin
        out_data <= ig_head[gnt];
        out_chan <= gnt;
        last_grant <= gnt;
      end
    end

  assign ret_ok = |ret_sel;
  assign ret_rdy = !(|(ret_sel & eg_full));
  assign eg_push = (ret_vld && ret_rdy) ? ret_sel : '0;
  assign eg_pop = chan_vld & chan_rdy;
  assign idle = &ig_empty && &eg_empty && !out_vld;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bad_chan_err <= 1'b0;
    else if (ret_vld && !ret_ok) bad_chan_err <= 1'b1;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [AW:0] iw, ir, ew, er;
    logic [DATA_WIDTH-1:0] im [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] em [FIFO_DEPTH];
    assign ret_sel[i] = ret_chan == IDX_W'(i);
    assign ig_empty[i] = iw == ir;
    assign ig_full[i] = (iw[AW] != ir[AW]) && (iw[AW-1:0] == ir[AW-1:0]);
    assign eg_empty[i] = ew == er;
    assign eg_full[i] = (ew[AW] != er[AW]) && (ew[AW-1:0] == er[AW-1:0]);
    assign ig_head[i] = im[ir[AW-1:0]];
    assign chan_vld[i] = !eg_empty[i];
    assign chan_data[i*DATA_WIDTH +: DATA_WIDTH] = em[er[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        iw <= '0;
        ir <= '0;
        ew <= '0;
        er <= '0;
      end else begin
        iw <= iw + {{AW{1'b0}}, ig_push[i]};
        ir <= ir + {{AW{1'b0}}, ig_pop[i]};
        ew <= ew + {{AW{1'b0}}, eg_push[i]};
        er <= er + {{AW{1'b0}}, eg_pop[i]};
      end
    always_ff @(posedge clk) begin
      if (ig_push[i]) im[iw[AW-1:0]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
      if (eg_push[i]) em[ew[AW-1:0]] <= ret_data;
    end
  end
endmodule
